slave_port_burst: RTL and testbench

- Next-generation serial-bus slave port.
- Generalises the single-bit, single-word slave port in three ways:
  - a LANES-bit wide serial path;
  - burst transfers with an incrementing, wrapping address;
  - a parametrised split latency.
- Sits between the bus interconnect and a slave BRAM. It drops into the same position as the existing slave port, with the same memory-side handshake.

---
 rtl/slave_port_burst_pkg.sv | 26 ++
 rtl/slave_port_burst_serial_shifter.sv | 48 ++++
 rtl/slave_port_burst.sv | 197 +++++++++++++++++++
 tb/tb_slave_port_burst.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_port_burst_pkg.sv
// Shared definitions for the burst slave port: FSM encoding, beat arithmetic
// and the elaboration-time lane-width check.
package slave_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_SPLIT,
    ST_SGNT,
    ST_RREQ,
    ST_RDATA
  } sp_state_t;

  function automatic int beat_count(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

`ifndef SP_LANE_CHECK
`define SP_LANE_CHECK(W, L, LBL) \
  if (((W) % (L)) != 0) begin : LBL \
    $error("slave_port_burst: width %0d is not a multiple of LANES=%0d", (W), (L)); \
  end
`endif

// File: rtl/slave_port_burst_serial_shifter.sv
// LANES-wide right shift register with a beat counter; done marks the edge
// on which the final beat of a field is consumed.
module serial_shifter #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LANES-1:0] din,
  input  logic [CW-1:0]    last,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt,
  output logic [LANES-1:0] dout,
  output logic             done
);

  logic [CW-1:0] cnt;

  // New beats enter at the top so an LSB-first field ends up right-aligned.
  generate
    if (WIDTH == LANES) begin : g_one
      assign q_nxt = din;
    end else begin : g_multi
      assign q_nxt = {din, q[WIDTH-1:LANES]};
    end
  endgenerate

  assign dout = q[LANES-1:0];
  assign done = shift && (cnt == last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_data;
      cnt <= '0;
    end else if (shift) begin
      q   <= q_nxt;
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slave_port_burst.sv
// Serial-bus burst slave port: LANES-wide header/data beats, incrementing
// wrapping burst address, optional split read with programmable latency.
//
// state | meaning
// IDLE  | ready for the first header beat (sready=1)
// HDR   | collecting remaining address/length beats
// WDATA | collecting write words, strobing each one a cycle after completion
// SPLIT | split read: bus released for SPLIT_LATENCY cycles (ssplit=1)
// SGNT  | waiting for split_grant
// RREQ  | memory read request held until rvalid
// RDATA | shifting the captured word out to the master
module slave_port_burst
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 2,
  parameter int BLEN_WIDTH    = 4,
  parameter int SPLIT_EN      = 0,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LANES-1:0]      swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  input  logic                  split_grant,
  output logic [LANES-1:0]      srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  rvalid,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata
);

  `SP_LANE_CHECK(ADDR_WIDTH, LANES, g_chk_addr)
  `SP_LANE_CHECK(DATA_WIDTH, LANES, g_chk_data)
  `SP_LANE_CHECK(BLEN_WIDTH, LANES, g_chk_blen)
  if (SPLIT_LATENCY < 1 || SPLIT_LATENCY > 255) begin : g_chk_lat
    $error("slave_port_burst: SPLIT_LATENCY %0d outside 1..255", SPLIT_LATENCY);
  end

  localparam int HDR_W      = ADDR_WIDTH + BLEN_WIDTH;
  localparam int HDR_BEATS  = beat_count(HDR_W, LANES);
  localparam int DATA_BEATS = beat_count(DATA_WIDTH, LANES);
  localparam int RX_W       = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
  localparam int MAX_BEATS  = (HDR_BEATS > DATA_BEATS) ? HDR_BEATS : DATA_BEATS;
  localparam int CW         = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0] HDR_LAST   = CW'(HDR_BEATS - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_BEATS - 1);
  localparam logic [7:0]    SPLIT_LAST = 8'(SPLIT_LATENCY - 1);

  sp_state_t state, state_nxt, hdr_target;

  logic                  mode_q;
  logic                  hdr_mode;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BLEN_WIDTH-1:0] words_left;
  logic [7:0]            split_cnt;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  sready_st;

  logic                  rx_shift, rx_done;
  logic [CW-1:0]         rx_last;
  logic [RX_W-1:0]       rx_nxt, rx_q_unused;
  logic [LANES-1:0]      rx_dout_unused;
  logic [HDR_W-1:0]      hdr_word;
  logic                  hdr_done, word_done;

  logic                  tx_shift, tx_load, tx_done;
  logic [DATA_WIDTH-1:0] tx_q_unused, tx_nxt_unused;
  logic [LANES-1:0]      tx_dout;

  assign rx_shift  = mvalid && (state inside {ST_IDLE, ST_HDR, ST_WDATA});
  assign rx_last   = (state == ST_WDATA) ? DATA_LAST : HDR_LAST;
  assign hdr_word  = rx_nxt[RX_W-1 -: HDR_W];
  assign hdr_done  = rx_done && (state inside {ST_IDLE, ST_HDR});
  assign word_done = rx_done && (state == ST_WDATA);
  assign tx_shift  = (state == ST_RDATA);

  // Mode comes straight from the pin when the header is a single beat.
  assign hdr_mode   = (state == ST_IDLE) ? smode : mode_q;
  assign hdr_target = hdr_mode ? ST_WDATA : ((SPLIT_EN != 0) ? ST_SPLIT : ST_RREQ);

  serial_shifter #(.WIDTH(RX_W), .LANES(LANES), .CW(CW)) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .shift     (rx_shift),
    .load      (1'b0),
    .load_data ({RX_W{1'b0}}),
    .din       (swdata),
    .last      (rx_last),
    .q         (rx_q_unused),
    .q_nxt     (rx_nxt),
    .dout      (rx_dout_unused),
    .done      (rx_done)
  );

  serial_shifter #(.WIDTH(DATA_WIDTH), .LANES(LANES), .CW(CW)) u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .shift     (tx_shift),
    .load      (tx_load),
    .load_data (smemrdata),
    .din       ({LANES{1'b0}}),
    .last      (DATA_LAST),
    .q         (tx_q_unused),
    .q_nxt     (tx_nxt_unused),
    .dout      (tx_dout),
    .done      (tx_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    smemren   = 1'b0;
    svalid    = 1'b0;
    ssplit    = 1'b0;
    sready_st = 1'b0;
    case (state)
      ST_IDLE: begin
        sready_st = 1'b1;
        if (mvalid) state_nxt = rx_done ? hdr_target : ST_HDR;
      end
      ST_HDR:   if (rx_done) state_nxt = hdr_target;
      ST_WDATA: if (rx_done && words_left == '0) state_nxt = ST_IDLE;
      ST_SPLIT: begin
        ssplit = 1'b1;
        if (split_cnt == SPLIT_LAST) state_nxt = ST_SGNT;
      end
      ST_SGNT:  if (split_grant) state_nxt = ST_RREQ;
      ST_RREQ: begin
        smemren = 1'b1;
        if (rvalid) begin
          tx_load   = 1'b1;
          state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        svalid = 1'b1;
        if (tx_done) state_nxt = (words_left == '0) ? ST_IDLE : ST_RREQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q     <= 1'b0;
      addr_q     <= '0;
      words_left <= '0;
      split_cnt  <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wen_q <= 1'b0;
      if (state == ST_IDLE && mvalid) mode_q <= smode;
      if (hdr_done) begin
        addr_q     <= hdr_word[ADDR_WIDTH-1:0];
        words_left <= hdr_word[HDR_W-1 -: BLEN_WIDTH];
        split_cnt  <= '0;
      end
      if (state == ST_SPLIT) split_cnt <= split_cnt + 8'd1;
      // Write strobe is registered so the next word's beats never stall.
      if (word_done) begin
        wen_q      <= 1'b1;
        waddr_q    <= addr_q;
        wdata_q    <= rx_nxt[RX_W-1 -: DATA_WIDTH];
        addr_q     <= addr_q + 1'b1;
        words_left <= words_left - 1'b1;
      end
      if (tx_done) begin
        addr_q     <= addr_q + 1'b1;
        words_left <= words_left - 1'b1;
      end
    end
  end

  assign sready    = rstn && sready_st;
  assign srdata    = svalid ? tx_dout : '0;
  assign smemwen   = wen_q;
  assign smemaddr  = wen_q ? waddr_q : addr_q;
  assign smemwdata = wdata_q;

endmodule

// File: tb/tb_slave_port_burst.sv
// Randomised bench for slave_port_burst: one non-split and one split instance
// checked against a transaction-level model of bursts, memory and timing.
module tb_slave_port_burst;

  localparam int SPLIT_LAT = 4;

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] swdata;
  logic       smode, mv, split_grant, rvalid, sel;
  logic [7:0] smemrdata;
  logic       mvalid0, mvalid1;

  logic [1:0]  srdata0, srdata1, srdata;
  logic        svalid0, svalid1, svalid, sready0, sready1, sready;
  logic        ssplit0, ssplit1, ssplit, smemwen0, smemwen1, smemwen;
  logic        smemren0, smemren1, smemren;
  logic [11:0] smemaddr0, smemaddr1, smemaddr;
  logic [7:0]  smemwdata0, smemwdata1;

  logic [7:0] mem [4096];
  wr_t        wq0[$], wq1[$];
  int         cyc = 0;
  int         lastd;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mvalid0  = mv && !sel;
  assign mvalid1  = mv && sel;
  assign srdata   = sel ? srdata1 : srdata0;
  assign svalid   = sel ? svalid1 : svalid0;
  assign sready   = sel ? sready1 : sready0;
  assign ssplit   = sel ? ssplit1 : ssplit0;
  assign smemwen  = sel ? smemwen1 : smemwen0;
  assign smemren  = sel ? smemren1 : smemren0;
  assign smemaddr = sel ? smemaddr1 : smemaddr0;

  slave_port_burst #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .LANES(2), .BLEN_WIDTH(4),
                     .SPLIT_EN(0), .SPLIT_LATENCY(SPLIT_LAT)) u_dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid0),
    .split_grant(split_grant), .srdata(srdata0), .svalid(svalid0), .sready(sready0),
    .ssplit(ssplit0), .smemrdata(smemrdata), .rvalid(rvalid), .smemwen(smemwen0),
    .smemren(smemren0), .smemaddr(smemaddr0), .smemwdata(smemwdata0)
  );

  slave_port_burst #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .LANES(2), .BLEN_WIDTH(4),
                     .SPLIT_EN(1), .SPLIT_LATENCY(SPLIT_LAT)) u_dut_split (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid1),
    .split_grant(split_grant), .srdata(srdata1), .svalid(svalid1), .sready(sready1),
    .ssplit(ssplit1), .smemrdata(smemrdata), .rvalid(rvalid), .smemwen(smemwen1),
    .smemren(smemren1), .smemaddr(smemaddr1), .smemwdata(smemwdata1)
  );

  always @(negedge clk) begin
    if (smemwen0) wq0.push_back('{a: int'(smemaddr0), d: int'(smemwdata0), c: cyc});
    if (smemwen1) wq1.push_back('{a: int'(smemaddr1), d: int'(smemwdata1), c: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] b, input logic m, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      mv = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    swdata = b;
    smode  = m;
    mv     = 1'b1;
    lastd  = cyc;
    tick();
    mv     = 1'b0;
    swdata = 2'($urandom);
  endtask

  // Header is the 16-bit value {len, addr}, sent LSB pair first.
  task automatic send_hdr(input int a, input int len, input logic m, input bit gaps);
    int hv;
    hv = a | (len << 12);
    for (int k = 0; k < 8; k++)
      send_beat(2'((hv >> (2 * k)) & 3), (k == 0) ? m : 1'($urandom), gaps);
  endtask

  task automatic do_write(input bit s, input int a, input int len, input logic [31:0] dv,
                          input bit gaps);
    int  expc[4];
    int  nq;
    wr_t e;
    sel = s;
    if (s) wq1.delete(); else wq0.delete();
    send_hdr(a, len, 1'b1, gaps);
    for (int w = 0; w <= len; w++) begin
      for (int k = 0; k < 4; k++)
        send_beat(2'((dv >> (8 * w + 2 * k)) & 3), 1'($urandom), gaps);
      expc[w] = lastd + 1;
    end
    chk("wr_ready_after", {31'd0, sready}, 32'd1);
    tick();
    tick();
    nq = s ? wq1.size() : wq0.size();
    chk("wr_count", nq, len + 1);
    for (int w = 0; w <= len; w++) begin
      if (w < nq) begin
        if (s) e = wq1.pop_front(); else e = wq0.pop_front();
        chk("wr_addr", e.a, (a + w) % 4096);
        chk("wr_data", e.d, (dv >> (8 * w)) & 255);
        chk("wr_cycle", e.c, expc[w]);
      end
    end
  endtask

  task automatic do_read(input bit s, input int a, input int len, input int lat0,
                         input int gdly, input int abort_beat);
    int n, bad, addr;
    sel = s;
    send_hdr(a, len, 1'b0, 1'b0);
    if (s) begin
      n   = 0;
      bad = 0;
      while (ssplit && n < 20) begin
        if (smemren) bad++;
        n++;
        tick();
      end
      chk("ssplit_cycles", n, SPLIT_LAT);
      repeat (gdly) begin
        if (smemren || ssplit) bad++;
        tick();
      end
      chk("split_no_ren", bad, 0);
      split_grant = 1'b1;
      tick();
      split_grant = 1'b0;
    end
    for (int w = 0; w <= len; w++) begin
      addr = (a + w) % 4096;
      chk("ren_rise", {31'd0, smemren}, 32'd1);
      chk("ren_addr", {20'd0, smemaddr}, addr);
      n = (w == 0) ? lat0 : $urandom_range(0, 3);
      repeat (n) begin
        split_grant = 1'($urandom);
        tick();
      end
      split_grant = 1'b0;
      chk("ren_hold", {31'd0, smemren}, 32'd1);
      rvalid    = 1'b1;
      smemrdata = mem[addr];
      tick();
      rvalid    = 1'b0;
      smemrdata = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        if (w == 0 && k == abort_beat) begin
          rstn = 1'b0;
          #1;
          chk("rst_outs_zero",
              {17'd0, srdata, svalid, sready, ssplit, smemwen, smemren, smemaddr},
              32'd0);
          mv = 1'b0;
          return;
        end
        chk("rd_svalid", {31'd0, svalid}, 32'd1);
        chk("rd_beat", {30'd0, srdata}, (mem[addr] >> (2 * k)) & 3);
        mv     = 1'($urandom);
        swdata = 2'($urandom);
        tick();
      end
      mv = 1'b0;
    end
    chk("rd_end_ready", {31'd0, sready}, 32'd1);
    chk("rd_end_svalid", {31'd0, svalid}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; swdata = '0; smode = 1'b0; mv = 1'b0; split_grant = 1'b0;
    rvalid = 1'b0; smemrdata = '0; sel = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h010] = 8'h96;
    tick();
    tick();
    chk("rst_in_outs", {17'd0, srdata, svalid, sready, ssplit, smemwen, smemren, smemaddr}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rst_ready", {31'd0, sready}, 32'd1);
    chk("rst_quiet", {30'd0, svalid, smemren}, 32'd0);
    tick();

    do_write(1'b0, 12'h123, 2, 32'h00FF3CA5, 1'b0);
    do_read (1'b0, 12'h010, 0, 3, 0, -1);
    do_read (1'b1, int'($urandom_range(0, 4095)), 1, 2, 10, -1);
    do_write(1'b0, 12'hFFF, 1, 32'h00005AC3, 1'b0);
    do_write(1'b0, 12'h123, 2, 32'h00FF3CA5, 1'b1);
    do_write(1'b1, 12'hFFE, 3, $urandom, 1'b1);

    wq0.delete();
    do_read(1'b0, 12'h200, 2, 1, 0, 1);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, sready}, 32'd1);
    chk("post_rst_no_wr", wq0.size(), 0);
    do_write(1'b0, 12'h456, 1, 32'h0000E71B, 1'b0);

    sel    = 1'b0;
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("idle_rvalid_ign", {30'd0, svalid, smemren}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      bit s;
      int a, len;
      s   = 1'($urandom);
      a   = $urandom_range(0, 4095);
      len = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        do_write(s, a, len, $urandom, 1'($urandom));
      else
        do_read(s, a, len, $urandom_range(0, 3), $urandom_range(0, 5), -1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
